accel_job_arbiter: RTL
======================

# accel_job_arbiter

Round-robin job arbiter and sequencer that shares one matrix-multiply accelerator (the PCPI wrapper around the N×N systolic core) between `NREQ` requesters, such as the CPU PCPI path and a DMA engine. It grants one requester at a time and issues a single-cycle start to the accelerator. It then waits for the accelerator's done, with a watchdog timeout, and returns a per-requester completion pulse plus error status. It sits between the requesters and the wrapper and drives the operand-source select used by the top-level memA/memB mux.

## Interface
- `NREQ`, 2 — number of requesters, 2..8.
- `TIMEOUT`, 1024 — maximum RUN cycles before a job is aborted, ≥ 4.
- `CNTW`, 16 — width of the completed-job counter.
- `clk` in 1 — clock, all logic on rising edge.
- `rst_n` in 1 — asynchronous, active-low reset.
- `req` in NREQ — level request per requester, held until its `cmplt` bit pulses.
- `gnt` out NREQ — one-hot grant, held from arbitration until the DONE cycle inclusive.
- `acc_sel` out $clog2(NREQ) — index of the granted requester; drives the operand mux; holds its last value when idle.
- `start_req` out 1 — to the wrapper; a one-cycle pulse per job.
- `acc_done` in 1 — done from the wrapper; may be a level signal.
- `cmplt` out NREQ — one-cycle completion pulse on the granted bit.
- `err` out 1 — valid with `cmplt`; 1 means the job timed out.
- `busy` out 1 — high in any state other than IDLE.
- `jobs_done` out CNTW — count of jobs completed without timeout; wraps modulo 2^CNTW.

## Operation
- States are IDLE, START, RUN and DONE.
- **IDLE**
  - If `req` is not zero, pick the winner with round-robin: search from `last+1` upward, with wrap, and take the first set bit.
  - Register `gnt` and `acc_sel`, then go to START.
  - If `req` is zero, stay in IDLE.
- **START**
  - `start_req` = 1 for this cycle only.
  - Clear the watchdog counter and the `armed` flag, then go to RUN.
- **RUN**
  - The watchdog counter increments every cycle.
  - `armed` sets the first cycle `acc_done` is sampled as 0. This stops a done level left over from the previous job from completing the new one.
  - If `armed` && `acc_done`: go to DONE with `err` = 0.
  - Otherwise, if the counter == TIMEOUT-1: go to DONE with `err` = 1.
  - If both conditions hold in the same cycle, done wins (`err` = 0).
- **DONE**
  - `cmplt[acc_sel]` = 1 and `err` is driven for this single cycle.
  - `last` ← `acc_sel`.
  - If `err` = 0, `jobs_done` increments.
  - `gnt` clears at the end of the cycle; go to IDLE.
- The granted requester dropping `req` during START or RUN does not abort the job. It still gets `cmplt`.
- Changes on ungranted `req` bits have no effect until the next IDLE arbitration.
- A requester that holds `req` high after `cmplt` is a new request. Round-robin gives every other pending requester one job first.
- `acc_done` is ignored outside RUN.

## Timing
- Reset values: `gnt` = 0, `acc_sel` = 0, `start_req` = 0, `cmplt` = 0, `err` = 0, `busy` = 0, `jobs_done` = 0, `last` = NREQ-1 (so requester 0 wins first), state = IDLE.
- The `req` sample at edge k gives `gnt`/`busy` at k+1 and the `start_req` pulse during cycle k+1.
- Earliest `cmplt` is 3 cycles after START, because `armed` needs one low sample of `acc_done`.
- Back-to-back jobs: from DONE to the next START takes 2 cycles (DONE → IDLE → START).
- A timeout job takes exactly TIMEOUT RUN cycles.
- Asserting reset mid-job returns to IDLE immediately and forces all outputs to their reset values.
  - The accelerator shares `rst_n`, so no job is left in flight.
  - `jobs_done` is cleared.
- All outputs are registered; there is no combinational path from input to output.

## Structure
- `accel_pkg` holds:
  - `arb_state_t` — a 2-bit enum with IDLE, START, RUN and DONE.
  - the localparam for the default TIMEOUT.
- One sub-module, `rr_pick`:
  - Combinational, parameterised by NREQ.
  - Inputs: `req` and `last`.
  - Outputs: a one-hot winner and its index; `any` = reduction-OR of `req`.
  - The arbiter instantiates it once.
- The watchdog counter width is $clog2(TIMEOUT).

## Test plan
- **Single requester:** `req` = 2'b01 with the accelerator model asserting `acc_done` 20 cycles after start.
  - One `start_req` pulse, `gnt` = 01, `cmplt` = 01 with `err` = 0, `jobs_done` = 1.
- **Fairness:** `req` = 2'b11 held for four jobs.
  - Grants go 0, 1, 0, 1; each `cmplt` on the matching bit; `jobs_done` = 4.
- **Stale done:** the model holds `acc_done` = 1 from the previous job into the next START and drops it 1 cycle later, then raises it 10 cycles later.
  - `cmplt` comes only after the second rising edge, not on the stale level.
- **Timeout:** TIMEOUT = 16, `acc_done` never asserted.
  - `cmplt` with `err` = 1 exactly 16 RUN cycles after START; `jobs_done` is unchanged.
  - The next request is served normally.
- **Requester drop:** requester 1 drops `req` mid-RUN.
  - The job completes; `cmplt[1]` still pulses; no extra `start_req`.
- **Reset mid-job:** `rst_n` low for 2 cycles during RUN with `jobs_done` = 3.
  - All outputs return to their reset values at once; after release, `req` = 2'b10 is granted to requester 1 first.

Source files
------------

// File: rtl/accel_pkg.sv
// Shared types and defaults for the accelerator job arbiter.
package accel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_t;

  localparam int unsigned TIMEOUT_DEFAULT = 1024;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request strictly after i_last, with wrap.
module rr_pick #(
  parameter  int NREQ = 2,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_last,
  output logic [NREQ-1:0] o_win,
  output logic [IW-1:0]   o_idx,
  output logic            o_any
);

  assign o_any = |i_req;

  // Walk from lowest to highest priority so the nearest candidate is written last.
  always_comb begin
    o_win = '0;
    o_idx = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (i_req[(int'(i_last) + k) % NREQ]) begin
        o_win = '0;
        o_win[(int'(i_last) + k) % NREQ] = 1'b1;
        o_idx = IW'((int'(i_last) + k) % NREQ);
      end
    end
  end

endmodule

// File: rtl/accel_job_arbiter.sv
// Round-robin arbiter/sequencer sharing one accelerator between NREQ requesters.
// state | meaning
// IDLE  | waiting for any request; arbitrates and registers the grant
// START | one-cycle start pulse to the accelerator; watchdog cleared
// RUN   | waiting for a fresh done (after one low sample) or the watchdog
// DONE  | completion pulse + error to the granted requester
module accel_job_arbiter
  import accel_pkg::*;
#(
  parameter  int NREQ    = 2,
  parameter  int TIMEOUT = TIMEOUT_DEFAULT,
  parameter  int CNTW    = 16,
  localparam int SW      = $clog2(NREQ),
  localparam int CW      = $clog2(TIMEOUT)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [NREQ-1:0] i_req,
  output logic [NREQ-1:0] o_gnt,
  output logic [SW-1:0]   o_acc_sel,
  output logic            o_start_req,
  input  logic            i_acc_done,
  output logic [NREQ-1:0] o_cmplt,
  output logic            o_err,
  output logic            o_busy,
  output logic [CNTW-1:0] o_jobs_done
);

  arb_state_t      r_state, w_state_d;
  logic [NREQ-1:0] r_gnt, r_cmplt;
  logic [SW-1:0]   r_sel, r_last;
  logic            r_start, r_err, r_busy, r_armed;
  logic [CNTW-1:0] r_jobs;
  logic [CW-1:0]   r_wdog;
  logic [NREQ-1:0] w_win;
  logic [SW-1:0]   w_idx;
  logic            w_any, w_tmo;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .i_req  (i_req),
    .i_last (r_last),
    .o_win  (w_win),
    .o_idx  (w_idx),
    .o_any  (w_any)
  );

  always_comb begin
    w_state_d = r_state;
    w_tmo     = 1'b0;
    case (r_state)
      ST_IDLE:  if (w_any) w_state_d = ST_START;
      ST_START: w_state_d = ST_RUN;
      ST_RUN: begin
        // A done seen together with the watchdog expiry still counts as success.
        if (r_armed && i_acc_done) begin
          w_state_d = ST_DONE;
        end else if (r_wdog == CW'(TIMEOUT - 1)) begin
          w_state_d = ST_DONE;
          w_tmo     = 1'b1;
        end
      end
      ST_DONE:  w_state_d = ST_IDLE;
      default:  w_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_sel   <= '0;
      r_last  <= SW'(NREQ - 1);
      r_start <= 1'b0;
      r_cmplt <= '0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
      r_jobs  <= '0;
      r_wdog  <= '0;
      r_armed <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_start <= (r_state == ST_IDLE) && w_any;
      r_busy  <= (w_state_d != ST_IDLE);
      r_cmplt <= '0;
      r_err   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_gnt <= w_win;
            r_sel <= w_idx;
          end
        end
        ST_START: begin
          r_wdog  <= '0;
          r_armed <= 1'b0;
        end
        ST_RUN: begin
          r_wdog <= r_wdog + CW'(1);
          if (!i_acc_done) r_armed <= 1'b1;
          if (w_state_d == ST_DONE) begin
            r_cmplt <= r_gnt;
            r_err   <= w_tmo;
          end
        end
        ST_DONE: begin
          r_last <= r_sel;
          r_gnt  <= '0;
          if (!r_err) r_jobs <= r_jobs + CNTW'(1);
        end
        default: ;
      endcase
    end
  end

  assign o_gnt       = r_gnt;
  assign o_acc_sel   = r_sel;
  assign o_start_req = r_start;
  assign o_cmplt     = r_cmplt;
  assign o_err       = r_err;
  assign o_busy      = r_busy;
  assign o_jobs_done = r_jobs;

endmodule
